// File: rtl/alu_arbiter.sv
// Two-requester arbiter that time-shares one external combinational ALU, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter  int unsigned XLEN   = 32,
  localparam int unsigned CTRL_W = 5,
  localparam int unsigned FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic [FLAG_W-1:0] rsp_flags,

  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [FLAG_W-1:0] alu_flags,

  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rsp0_valid_d, rsp1_valid_d;
  logic [XLEN-1:0]     rsp_result_d;
  logic [FLAG_W-1:0]   rsp_flags_d;
  logic [XLEN-1:0]     alu_a_d, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_d;
  logic                grant_id_d;
  logic                busy_d;

  logic                owner_rsp_valid, owner_rsp_ready;
  logic                rsp_done, can_accept, any_valid, accept, win;

  // Response handshake of the current owner frees the datapath for a same-cycle accept.
  assign owner_rsp_valid = grant_id ? rsp1_valid : rsp0_valid;
  assign owner_rsp_ready = grant_id ? rsp1_ready : rsp0_ready;
  assign rsp_done        = (state_q == RESP) && owner_rsp_valid && owner_rsp_ready;
  assign can_accept      = (state_q == IDLE) || rsp_done;
  assign any_valid       = req0_valid || req1_valid;
  assign accept          = can_accept && any_valid;

`ifdef ALU_ARB_RR_EN
  // rr_prio_q names the requester that wins a tie; it points away from the last grant.
  logic rr_prio_q, rr_prio_d;

  assign win = (req0_valid && req1_valid) ? rr_prio_q : req1_valid;

  always_comb begin
    rr_prio_d = rr_prio_q;
    if (accept) rr_prio_d = ~win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_prio_q <= 1'b0;
    else        rr_prio_q <= rr_prio_d;
  end
`else
  assign win = ~req0_valid;
`endif

  // Ready goes only to the winner; reset holds both low.
  assign req0_ready = rst_n && accept && !win;
  assign req1_ready = rst_n && accept &&  win;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    rsp0_valid_d = rsp0_valid;
    rsp1_valid_d = rsp1_valid;
    rsp_result_d = rsp_result;
    rsp_flags_d  = rsp_flags;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_ctrl_d   = alu_ctrl;
    grant_id_d   = grant_id;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp0_valid_d = !grant_id;
        rsp1_valid_d = grant_id;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = accept ? EXEC : IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      grant_id_d = win;
      alu_a_d    = win ? req1_a    : req0_a;
      alu_b_d    = win ? req1_b    : req0_b;
      alu_ctrl_d = win ? req1_ctrl : req0_ctrl;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= CTRL_W'(0);
      grant_id   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp0_valid <= rsp0_valid_d;
      rsp1_valid <= rsp1_valid_d;
      rsp_result <= rsp_result_d;
      rsp_flags  <= rsp_flags_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_ctrl   <= alu_ctrl_d;
      grant_id   <= grant_id_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared ALU port.
// Build with ALU_ARB_RR_EN defined to check the round-robin variant.
module tb_alu_arbiter;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0] req0_ctrl, req1_ctrl;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [XLEN-1:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [4:0] alu_ctrl;
  logic [3:0] alu_flags;
  logic busy, grant_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .grant_id(grant_id)
  );

  // Environment ALU: add, sub, and; flags {N,Z,C,V}, C is carry-out (no-borrow on sub).
  logic [XLEN:0] alu_sum;
  logic          alu_v;
  always_comb begin
    alu_sum = '0;
    alu_v   = 1'b0;
    case (alu_ctrl)
      5'b0_0000: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v   = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      5'b1_0000: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_v   = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      5'b0_0111: alu_sum = {1'b0, alu_a & alu_b};
      default:   alu_sum = '0;
    endcase
    alu_result = alu_sum[31:0];
    alu_flags  = {alu_sum[31], (alu_sum[31:0] == '0), alu_sum[32], alu_v};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          k;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ctrl;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs [7];

  // Single operation from requester k, expected result and flags hand-computed in the table.
  task automatic do_op(input string name, input vec_t v);
    @(negedge clk);
    chk({name, "_idle"}, busy, 0);
    if (v.k == 1'b0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_ctrl = v.ctrl;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_ctrl = v.ctrl;
    end
    #1;
    chk({name, "_rdy0"}, req0_ready, v.k == 1'b0);
    chk({name, "_rdy1"}, req1_ready, v.k == 1'b1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({name, "_exec_busy"}, busy, 1);
    chk({name, "_exec_gid"}, grant_id, v.k);
    chk({name, "_alu_a"}, alu_a, v.a);
    chk({name, "_alu_b"}, alu_b, v.b);
    chk({name, "_alu_ctrl"}, alu_ctrl, v.ctrl);
    chk({name, "_exec_v"}, {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    chk({name, "_rsp0_v"}, rsp0_valid, v.k == 1'b0);
    chk({name, "_rsp1_v"}, rsp1_valid, v.k == 1'b1);
    chk({name, "_result"}, rsp_result, v.res);
    chk({name, "_flags"}, rsp_flags, v.flg);
    if (v.k == 1'b0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk({name, "_done_v"}, {rsp1_valid, rsp0_valid}, 0);
    chk({name, "_done_busy"}, busy, 0);
    chk({name, "_idle_hold"}, alu_a, v.a);
  endtask

  initial begin
    logic exp_g [4];
    vecs[0] = '{1'b0, 32'd5,        32'd3,        5'b0_0000, 32'd8,        4'b0000};
    vecs[1] = '{1'b1, 32'd3,        32'd3,        5'b1_0000, 32'd0,        4'b0110};
    vecs[2] = '{1'b0, 32'd1,        32'd2,        5'b1_0000, 32'hFFFFFFFF, 4'b1000};
    vecs[3] = '{1'b1, 32'h7FFFFFFF, 32'd1,        5'b0_0000, 32'h80000000, 4'b1001};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        5'b0_0000, 32'd0,        4'b0110};
    vecs[5] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 5'b0_0111, 32'hF000F000, 4'b1000};
    vecs[6] = '{1'b0, 32'h80000000, 32'd1,        5'b1_0000, 32'h7FFFFFFF, 4'b0011};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset values, with a request already pending.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_ctrl = 5'b0_0000;
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_rsp_v", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);

    // First rising edge after release accepts.
    rst_n = 1'b1;
    #1 chk("first_rdy", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("first_busy", busy, 1);
    chk("first_alu_a", alu_a, 32'd9);
    @(negedge clk);
    chk("first_rsp0_v", rsp0_valid, 1);
    chk("first_result", rsp_result, 32'd13);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    chk("first_done", busy, 0);

    for (int i = 0; i < 7; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Response back-pressure: everything holds, no new accept, foreign rsp_ready ignored.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_ctrl = 5'b1_0000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd555; req1_valid = 1'b1; req1_a = 32'd777;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stall%0d_v0", i), rsp0_valid, 1);
      chk($sformatf("stall%0d_v1", i), rsp1_valid, 0);
      chk($sformatf("stall%0d_res", i), rsp_result, 32'd77);
      chk($sformatf("stall%0d_flg", i), rsp_flags, 4'b0010);
      chk($sformatf("stall%0d_alu_a", i), alu_a, 32'd100);
      chk($sformatf("stall%0d_alu_b", i), alu_b, 32'd23);
      chk($sformatf("stall%0d_rdy", i), {req1_ready, req0_ready}, 0);
      chk($sformatf("stall%0d_busy", i), busy, 1);
      chk($sformatf("stall%0d_gid", i), grant_id, 0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    chk("stall_rel_v0", rsp0_valid, 0);
    chk("stall_rel_busy", busy, 0);

    // Handshake and pending req1 in the same cycle go straight back to EXEC.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd6; req0_ctrl = 5'b0_0111;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd5; req1_ctrl = 5'b1_0000;
    #1 chk("pend_exec_rdy1", req1_ready, 0);
    @(negedge clk);
    chk("pend_resp_rdy1", req1_ready, 0);
    chk("pend_resp_res", rsp_result, 32'd6);
    rsp0_ready = 1'b1;
    #1;
    chk("pend_hs_rdy1", req1_ready, 1);
    chk("pend_hs_rdy0", req0_ready, 0);
    @(negedge clk);
    req1_valid = 1'b0; rsp0_ready = 1'b0;
    chk("pend_exec_busy", busy, 1);
    chk("pend_exec_gid", grant_id, 1);
    chk("pend_exec_v", {rsp1_valid, rsp0_valid}, 0);
    chk("pend_exec_alu_a", alu_a, 32'd2);
    @(negedge clk);
    chk("pend_rsp1_v", rsp1_valid, 1);
    chk("pend_rsp0_v", rsp0_valid, 0);
    chk("pend_res", rsp_result, 32'hFFFFFFFD);
    chk("pend_flg", rsp_flags, 4'b1000);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    chk("pend_done", busy, 0);

    // Reset in EXEC discards the operation.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd1; req0_ctrl = 5'b0_0000;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_v", {rsp1_valid, rsp0_valid}, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_res", rsp_result, 0);
    chk("mid_rst_gid", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_v", i), {rsp1_valid, rsp0_valid}, 0);
      chk($sformatf("post_rst%0d_busy", i), busy, 0);
    end
    rsp0_ready = 1'b0;

    // Both requesters saturating with responses always accepted.
`ifdef ALU_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_ctrl = 5'b0_0000;
    req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_ctrl = 5'b1_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_exec_busy", i), busy, 1);
      chk($sformatf("sat%0d_exec_v", i), {rsp1_valid, rsp0_valid}, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_gid", i), grant_id, exp_g[i]);
      chk($sformatf("sat%0d_v0", i), rsp0_valid, exp_g[i] == 1'b0);
      chk($sformatf("sat%0d_v1", i), rsp1_valid, exp_g[i] == 1'b1);
      chk($sformatf("sat%0d_res", i), rsp_result, (exp_g[i] == 1'b0) ? 32'd11 : 32'd18);
      chk($sformatf("sat%0d_flg", i), rsp_flags, (exp_g[i] == 1'b0) ? 4'b0000 : 4'b0010);
`ifdef ALU_ARB_RR_EN
      chk($sformatf("sat%0d_rdy0", i), req0_ready, exp_g[i] == 1'b1);
      chk($sformatf("sat%0d_rdy1", i), req1_ready, exp_g[i] == 1'b0);
`else
      chk($sformatf("sat%0d_rdy0", i), req0_ready, 1);
      chk($sformatf("sat%0d_rdy1", i), req1_ready, 0);
`endif
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("sat_end_busy", busy, 0);
    chk("sat_end_v", {rsp1_valid, rsp0_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req0_valid/req1_valid  in  1  requester k has an operation pending.
REQ-005 req0_ready/req1_ready  out  1  arbiter accepts requester k's operation this cycle.
REQ-006 req0_a/req1_a, req0_b/req1_b  in  XLEN  operands of requester k.
REQ-007 req0_ctrl/req1_ctrl  in  5  ALU control code of requester k; passed through unchanged.
REQ-008 rsp0_valid/rsp1_valid  out  1  response for requester k held on shared response bus.
REQ-009 rsp0_ready/rsp1_ready  in  1  requester k consumes its response.
REQ-010 rsp_result  out  XLEN  registered ALU result of the owning operation.
REQ-011 rsp_flags  out  4  registered {N,Z,C,V} of the owning operation.
REQ-012 alu_a, alu_b  out  XLEN; alu_ctrl  out  5  registered operands/control to the shared combinational ALU.
REQ-013 alu_result  in  XLEN; alu_flags  in  4  ALU outputs, {N,Z,C,V}.
REQ-014 busy  out  1  high whenever state is not IDLE; grant_id  out  1  owner of current/last operation.

Function
REQ-015 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 Accept = reqk_valid & reqk_ready; at most one reqk_ready high per cycle, only for the arbitration winner.
REQ-017 reqk_ready high when state=IDLE, or state=RESP and the owning rsp handshake completes this cycle (combinational path rsp_ready->req_ready allowed).
REQ-018 On accept: winner's a/b/ctrl latched into alu_a/alu_b/alu_ctrl, grant_id=winner, state->EXEC.
REQ-019 In EXEC: alu_result/alu_flags latched into rsp_result/rsp_flags, rsp<grant_id>_valid set, state->RESP; latency accept edge to rsp_valid = 1 cycle.
REQ-020 In RESP: rsp_result, rsp_flags, grant_id, alu_* held stable until rsp<grant_id>_ready high; only rsp<grant_id>_valid may be high; other rsp_valid low.
REQ-021 On response handshake with no new accept: rsp_valid cleared, state->IDLE; with same-cycle accept: state->EXEC directly (one op per 2 cycles sustained).
REQ-022 rspk_ready ignored when rspk_valid low; reqk_valid with no grant remains pending, no internal queuing.
REQ-023 alu_* outputs hold last accepted values while IDLE.

Reset
REQ-024 rst_n low asynchronously forces state=IDLE, all rsp_valid=0, all req_ready=0, busy=0, grant_id=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_ctrl=5'b0_0000, RR pointer to favour requester 0.
REQ-025 Reset during EXEC or RESP discards the in-flight operation; no response is ever issued for it.
REQ-026 First accept allowed on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; when both valid, winner is requester not granted last; single valid always wins.
REQ-028 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; RR pointer logic absent.

Verification
REQ-029 req0 add (ctrl 5'b0_0000) a=5 b=3 accepted at cycle 0 -> rsp0_valid cycle 1, rsp_result=8, rsp_flags=4'b0000.
REQ-030 req1 sub (ctrl 5'b1_0000) a=3 b=3 -> rsp1_valid only, rsp_result=0, rsp_flags=4'b0110 (Z=1,C=1), rsp0_valid stays 0.
REQ-031 Both valid continuously, rsp_ready tied 1 -> RR build: grants 0,1,0,1 every 2 cycles; fixed build: grants 0,0,0,0, req1_ready never high.
REQ-032 rsp0_ready low 4 cycles after result -> rsp_result/rsp_flags/alu_* stable, req0_ready and req1_ready low, busy=1; release -> rsp0_valid drops next cycle.
REQ-033 rst_n pulsed low during EXEC of a=7 b=1 -> outputs at reset values immediately, no rsp_valid afterwards; new request post-reset completes normally.
REQ-034 Response handshake and pending req1 in same cycle -> req1_ready=1 that cycle, state EXEC next, rsp1_valid one cycle later.
